// File: rtl/melody_sequencer.sv
// Melody sequencer: drives the note decoder either from the manual switches or
// from a small beat-timed melody table played back by a five-state controller.
module melody_sequencer #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int TICKS_PER_BEAT = 25_000_000,
    parameter int GAP_TICKS      = 2_500_000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    SW,
    input  logic          PLAY,
    input  logic          STOP,
    input  logic          LOOP,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [7:0]    WR_NOTE,
    input  logic [3:0]    WR_DUR,
    output logic [7:0]    NOTE,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] STEP,
    output logic [2:0]    DBG_STATE
);

    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [AW-1:0] STEP_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_NOTE_ON = 3'd2,
        S_GAP     = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_adv_state;
    logic [AW-1:0] r_step;
    logic [AW-1:0] w_step_nxt;
    logic [AW-1:0] w_adv_step;
    logic [7:0]    r_note;
    logic [7:0]    w_note_nxt;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_beat;
    logic [GW-1:0] r_gap;
    logic [11:0]   r_table [DEPTH];

    logic [11:0]   w_entry;
    logic [7:0]    w_entry_note;
    logic [3:0]    w_entry_dur;
    logic          w_beat_end;
    logic          w_gap_end;

    // Table contents cannot change outside IDLE, so the entry at r_step is
    // stable for the whole LOAD/NOTE_ON/GAP span of that step.
    assign w_entry      = r_table[r_step];
    assign w_entry_note = w_entry[11:4];
    assign w_entry_dur  = w_entry[3:0];
    assign w_beat_end   = (r_tick == TICK_LAST) && (r_beat == 4'd1);
    assign w_gap_end    = (r_gap == GAP_LAST);

    always_comb begin
        w_adv_state = S_LOAD;
        w_adv_step  = r_step + 1'b1;
        if (r_step == STEP_LAST) begin
            if (LOOP) begin
                w_adv_step = '0;
            end else begin
                w_adv_state = S_FINISH;
                w_adv_step  = r_step;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            S_IDLE: begin
                if (PLAY && !STOP) begin
                    w_state_nxt = S_LOAD;
                    w_step_nxt  = '0;
                end
            end
            S_LOAD: begin
                if (w_entry_dur == 4'd0) begin
                    // Looping back only from a non-zero step keeps an empty table from spinning.
                    if (LOOP && (r_step != '0)) begin
                        w_state_nxt = S_LOAD;
                        w_step_nxt  = '0;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end else begin
                    w_state_nxt = S_NOTE_ON;
                end
            end
            S_NOTE_ON: begin
                if (w_beat_end) begin
                    if (GAP_TICKS > 0) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = w_adv_state;
                        w_step_nxt  = w_adv_step;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = w_adv_state;
                    w_step_nxt  = w_adv_step;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (STOP && ((r_state == S_LOAD) || (r_state == S_NOTE_ON) || (r_state == S_GAP))) begin
            w_state_nxt = S_FINISH;
            w_step_nxt  = r_step;
        end
    end

    // NOTE is registered from the next state so it lines up with the state it belongs to.
    always_comb begin
        w_note_nxt = 8'd0;
        case (w_state_nxt)
            S_IDLE:    w_note_nxt = SW;
            S_NOTE_ON: w_note_nxt = w_entry_note;
            default:   w_note_nxt = 8'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_note  <= 8'd0;
            r_tick  <= '0;
            r_beat  <= 4'd0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_note  <= w_note_nxt;
            case (r_state)
                S_LOAD: begin
                    r_tick <= '0;
                    r_beat <= w_entry_dur;
                end
                S_NOTE_ON: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        r_beat <= r_beat - 4'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_tick <= r_tick;
                    r_beat <= r_beat;
                end
            endcase
            if (r_state == S_GAP) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 12'd0;
            end
        end else if (WR_EN && (r_state == S_IDLE)) begin
            r_table[WR_ADDR] <= {WR_NOTE, WR_DUR};
        end
    end

    assign NOTE      = r_note;
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = (r_state == S_FINISH);
    assign STEP      = r_step;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle expected outputs are queued by the
// driver and popped/compared by an independent negedge monitor.
module tb_melody_sequencer;

  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    sw;
  logic          play;
  logic          stop;
  logic          loop_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_note;
  logic [3:0]    wr_dur;
  logic [7:0]    note;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;
  logic [2:0]    dbg_state;

  // exp word: {step_valid, note[7:0], busy, done, step[3:0]}
  logic [14:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;

  melody_sequencer #(
    .DEPTH(16),
    .AW(AW),
    .TICKS_PER_BEAT(4),
    .GAP_TICKS(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .SW(sw),
    .PLAY(play),
    .STOP(stop),
    .LOOP(loop_en),
    .WR_EN(wr_en),
    .WR_ADDR(wr_addr),
    .WR_NOTE(wr_note),
    .WR_DUR(wr_dur),
    .NOTE(note),
    .BUSY(busy),
    .DONE(done),
    .STEP(step),
    .DBG_STATE(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // expected-value builders
  function automatic logic [14:0] e_rst();
    return {1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
  endfunction
  function automatic logic [14:0] e_idle(input logic [7:0] s);
    return {1'b0, s, 1'b0, 1'b0, 4'd0};
  endfunction
  function automatic logic [14:0] e_load(input logic [3:0] st);
    return {1'b1, 8'h00, 1'b1, 1'b0, st};
  endfunction
  function automatic logic [14:0] e_on(input logic [7:0] n, input logic [3:0] st);
    return {1'b1, n, 1'b1, 1'b0, st};
  endfunction
  function automatic logic [14:0] e_gap(input logic [3:0] st);
    return {1'b1, 8'h00, 1'b1, 1'b0, st};
  endfunction
  function automatic logic [14:0] e_fin(input logic [3:0] st);
    return {1'b1, 8'h00, 1'b1, 1'b1, st};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [14:0] e;
    string       nm;
    logic        ok;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      ok = (note == e[13:6]) && (busy == e[5]) && (done == e[4]) && (!e[14] || (step == e[3:0]));
      if (!ok) begin
        bad++;
        $display("FAIL %s: got note=%h busy=%b done=%b step=%0d, want note=%h busy=%b done=%b step=%0d%s",
                 nm, note, busy, done, step, e[13:6], e[5], e[4], e[3:0], e[14] ? "" : "(any)");
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic [14:0] e, input string nm);
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [7:0] n, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_note = n;
    wr_dur  = d;
    cyc(e_idle(sw), "write_idle");
    wr_en = 1'b0;
  endtask

  task automatic start_play();
    play = 1'b1;
    cyc(e_load(4'd0), "play_load");
    play = 1'b0;
  endtask

  task automatic note_and_gap(input logic [7:0] n, input int dur, input logic [3:0] st);
    for (int k = 0; k < dur * 4; k++) cyc(e_on(n, st), "note_on");
    for (int k = 0; k < 2; k++) cyc(e_gap(st), "gap");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(e_rst(), "reset");
    cyc(e_rst(), "reset");
    rst = 1'b0;
    cyc({1'b1, sw, 1'b0, 1'b0, 4'd0}, "post_reset_idle");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    sw      = 8'h05;
    play    = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_note = 8'h00;
    wr_dur  = 4'd0;

    // reset / idle pass-through
    do_reset();
    sw = 8'hC8;
    cyc(e_idle(8'hC8), "idle_passthru_hi");
    sw = 8'h05;
    cyc(e_idle(8'h05), "idle_passthru");

    // basic play, LOOP=0
    write_entry(4'd0, 8'h0A, 4'd2);
    write_entry(4'd1, 8'h13, 4'd1);
    write_entry(4'd2, 8'h00, 4'd0);
    start_play();
    note_and_gap(8'h0A, 2, 4'd0);
    cyc(e_load(4'd1), "load1");
    note_and_gap(8'h13, 1, 4'd1);
    cyc(e_load(4'd2), "load2");
    cyc(e_fin(4'd2), "finish");
    cyc(e_idle(sw), "idle_after");
    cyc(e_idle(sw), "idle_no_done");

    // loop back to entry 0, then STOP during the second 0A
    loop_en = 1'b1;
    start_play();
    note_and_gap(8'h0A, 2, 4'd0);
    cyc(e_load(4'd1), "loop_load1");
    note_and_gap(8'h13, 1, 4'd1);
    cyc(e_load(4'd2), "loop_load2");
    cyc(e_load(4'd0), "loop_wrap_load0");
    for (int k = 0; k < 3; k++) cyc(e_on(8'h0A, 4'd0), "loop_note_again");
    stop = 1'b1;
    cyc(e_fin(4'd0), "stop_finish");
    stop = 1'b0;
    cyc(e_idle(sw), "stop_idle");

    // empty table with LOOP=1 must not spin
    do_reset();
    start_play();
    cyc(e_fin(4'd0), "empty_finish");
    cyc(e_idle(sw), "empty_idle");
    cyc(e_idle(sw), "empty_idle2");
    loop_en = 1'b0;

    // full table walk through all 16 entries
    for (int i = 0; i < 16; i++) write_entry(4'(i), 8'(i + 1), 4'd1);
    start_play();
    for (int i = 0; i < 16; i++) begin
      note_and_gap(8'(i + 1), 1, 4'(i));
      if (i < 15) cyc(e_load(4'(i + 1)), "wrap_load");
    end
    cyc(e_fin(4'd15), "wrap_finish");
    cyc(e_idle(sw), "wrap_idle");

    // PLAY and WR_EN ignored while busy
    start_play();
    cyc(e_on(8'h01, 4'd0), "busy_note");
    play    = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_note = 8'h1F;
    wr_dur  = 4'd3;
    cyc(e_on(8'h01, 4'd0), "busy_ignore_play");
    play  = 1'b0;
    wr_en = 1'b0;
    cyc(e_on(8'h01, 4'd0), "busy_note");
    stop = 1'b1;
    cyc(e_fin(4'd0), "busy_stop");
    stop = 1'b0;
    cyc(e_idle(sw), "busy_idle");
    start_play();
    for (int k = 0; k < 4; k++) cyc(e_on(8'h01, 4'd0), "e0_unchanged");
    cyc(e_gap(4'd0), "e0_dur_unchanged");
    stop = 1'b1;
    cyc(e_fin(4'd0), "gap_stop");
    stop = 1'b0;
    cyc(e_idle(sw), "gap_stop_idle");

    // PLAY+STOP together in IDLE
    sw   = 8'h2A;
    play = 1'b1;
    stop = 1'b1;
    cyc(e_idle(8'h2A), "play_stop_idle");
    play = 1'b0;
    stop = 1'b0;
    cyc(e_idle(8'h2A), "play_stop_idle2");

    // RST during NOTE_ON clears the table
    start_play();
    cyc(e_on(8'h01, 4'd0), "pre_rst_note");
    cyc(e_on(8'h01, 4'd0), "pre_rst_note");
    rst = 1'b1;
    cyc(e_rst(), "mid_reset");
    rst = 1'b0;
    cyc({1'b1, 8'h2A, 1'b0, 1'b0, 4'd0}, "mid_reset_idle");
    start_play();
    cyc(e_fin(4'd0), "cleared_finish");
    cyc(e_idle(8'h2A), "cleared_idle");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
